// File: rtl/zeroriscy_ex_ctrl_pkg.sv
// zeroriscy_ex_ctrl_pkg: shared types and helpers for the EX-stage sequencer
package zeroriscy_ex_ctrl_pkg;
  typedef enum logic [1:0] {EXC_IDLE, EXC_BUSY} ex_ctrl_state_e;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MULTDIV = 2'd1, WB_BNN = 2'd2, WB_LSU = 2'd3} ex_wb_sel_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_MULTDIV, OWN_LSU, OWN_BNN} ex_owner_e;
  function automatic ex_wb_sel_e owner_to_wb(ex_owner_e o);
    return o == OWN_MULTDIV ? WB_MULTDIV : o == OWN_LSU ? WB_LSU : o == OWN_BNN ? WB_BNN : WB_ALU;
  endfunction
  function automatic int wdog_width(int cycles);
    int w;
    w = $clog2(cycles);
    return w < 8 ? 8 : w > 16 ? 16 : w;
  endfunction
endpackage

// File: rtl/zeroriscy_ex_ctrl_if.sv
// zeroriscy_ex_ctrl_if: ID/unit handshake bundle seen by the EX-stage sequencer
interface zeroriscy_ex_ctrl_if #(parameter int STALL_CNT_W = 16);
  logic                   mult_en_i;
  logic                   div_en_i;
  logic                   lsu_en_i;
  logic                   bnn_en_i;
  logic                   multdiv_ready_i;
  logic                   lsu_ready_ex_i;
  logic                   bnn_ready_i;
  logic                   ex_ready_o;
  logic [1:0]             wb_sel_o;
  logic                   ex_busy_o;
  logic                   en_conflict_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;
  logic                   wdog_timeout_o;
  modport master (
    output mult_en_i, div_en_i, lsu_en_i, bnn_en_i, multdiv_ready_i, lsu_ready_ex_i, bnn_ready_i,
    input  ex_ready_o, wb_sel_o, ex_busy_o, en_conflict_o, stall_cnt_o, wdog_timeout_o
  );
  modport slave (
    input  mult_en_i, div_en_i, lsu_en_i, bnn_en_i, multdiv_ready_i, lsu_ready_ex_i, bnn_ready_i,
    output ex_ready_o, wb_sel_o, ex_busy_o, en_conflict_o, stall_cnt_o, wdog_timeout_o
  );
endinterface

// File: rtl/zeroriscy_ex_ctrl_prio_enc.sv
// zeroriscy_ex_prio_enc: fixed-priority unit select (multdiv > lsu > bnn) with conflict flag
module zeroriscy_ex_prio_enc
  import zeroriscy_ex_ctrl_pkg::*;
(
  input  logic      md_en_i,
  input  logic      lsu_en_i,
  input  logic      bnn_en_i,
  output ex_owner_e winner_o,
  output logic      conflict_o
);
  assign winner_o   = md_en_i ? OWN_MULTDIV : lsu_en_i ? OWN_LSU : bnn_en_i ? OWN_BNN : OWN_NONE;
  assign conflict_o = (md_en_i & lsu_en_i) | (md_en_i & bnn_en_i) | (lsu_en_i & bnn_en_i);
endmodule

// File: rtl/zeroriscy_ex_ctrl.sv
// zeroriscy_ex_ctrl: EX-stage multi-cycle sequencer; optional watchdog under ZERORISCY_EX_WDOG_EN
module zeroriscy_ex_ctrl
  import zeroriscy_ex_ctrl_pkg::*;
#(
  parameter bit RV32M       = 1'b1,
  parameter int STALL_CNT_W = 16,
  parameter int WDOG_CYCLES = 255
) (
  input logic               clk,
  input logic               rst_n,
  zeroriscy_ex_ctrl_if.slave ex
);
  ex_ctrl_state_e         state_q, state_d;
  ex_owner_e              owner_q, owner_d, winner;
  ex_wb_sel_e             wb_sel;
  logic                   md_en, conflict, conflict_q;
  logic                   win_ready, own_ready, own_en, ready, wdog_expire;
  logic [STALL_CNT_W-1:0] stall_q;

  assign md_en = RV32M && (ex.mult_en_i || ex.div_en_i);

  zeroriscy_ex_prio_enc u_prio (
    .md_en_i   (md_en),
    .lsu_en_i  (ex.lsu_en_i),
    .bnn_en_i  (ex.bnn_en_i),
    .winner_o  (winner),
    .conflict_o(conflict)
  );

  assign win_ready = winner == OWN_MULTDIV ? ex.multdiv_ready_i :
                     winner == OWN_LSU     ? ex.lsu_ready_ex_i  :
                     winner == OWN_BNN     ? ex.bnn_ready_i     : 1'b1;
  assign own_ready = owner_q == OWN_MULTDIV ? ex.multdiv_ready_i :
                     owner_q == OWN_LSU     ? ex.lsu_ready_ex_i  :
                     owner_q == OWN_BNN     ? ex.bnn_ready_i     : 1'b1;
  assign own_en    = owner_q == OWN_MULTDIV ? md_en       :
                     owner_q == OWN_LSU     ? ex.lsu_en_i :
                     owner_q == OWN_BNN     ? ex.bnn_en_i : 1'b0;

`ifdef ZERORISCY_EX_WDOG_EN
  localparam int WDOG_W = wdog_width(WDOG_CYCLES);
  logic [WDOG_W-1:0] wdog_q;
  // A late ready or a flush wins over expiry, so only a live, still-waiting op times out
  assign wdog_expire = state_q == EXC_BUSY && own_en && !own_ready && wdog_q == WDOG_W'(WDOG_CYCLES - 1);
  // BUSY-cycle counter, zero on every BUSY entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= (state_q == EXC_BUSY && state_d == EXC_BUSY) ? wdog_q + 1'b1 : '0;
  end
`else
  assign wdog_expire = 1'b0;
`endif

  // Next state, owner latch, ready and write-back select
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ready   = 1'b1;
    wb_sel  = WB_ALU;
    if (state_q == EXC_IDLE) begin
      wb_sel = owner_to_wb(winner);
      ready  = win_ready;
      if (!win_ready) begin
        state_d = EXC_BUSY;
        owner_d = winner;
      end
    end else begin
      wb_sel = owner_to_wb(owner_q);
      ready  = own_ready || wdog_expire;
      if (own_ready || !own_en || wdog_expire) begin
        state_d = EXC_IDLE;
        owner_d = OWN_NONE;
      end
    end
  end

  // State, owner and conflict pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EXC_IDLE;
      owner_q    <= OWN_NONE;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      conflict_q <= state_q == EXC_IDLE && conflict;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= (!ready && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
  end

  assign ex.ex_ready_o     = ready;
  assign ex.wb_sel_o       = wb_sel;
  assign ex.ex_busy_o      = state_q == EXC_BUSY;
  assign ex.en_conflict_o  = conflict_q;
  assign ex.stall_cnt_o    = stall_q;
  assign ex.wdog_timeout_o = wdog_expire;
endmodule

// File: tb/tb_zeroriscy_ex_ctrl.sv
// tb_zeroriscy_ex_ctrl: table-driven bench for the EX-stage sequencer
module tb_zeroriscy_ex_ctrl;
  localparam int SW   = 6;
  localparam int SMAX = (1 << SW) - 1;

  typedef struct packed {
    logic [6:0] in;
    logic       rdy;
    logic [1:0] wb;
    logic       busy;
    logic       conf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_stall = 0;
  vec_t tv[17];

  zeroriscy_ex_ctrl_if #(.STALL_CNT_W(SW)) ex_if();

  zeroriscy_ex_ctrl #(.RV32M(1'b1), .STALL_CNT_W(SW), .WDOG_CYCLES(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ex   (ex_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] v);
    {ex_if.mult_en_i, ex_if.div_en_i, ex_if.lsu_en_i, ex_if.bnn_en_i,
     ex_if.multdiv_ready_i, ex_if.lsu_ready_ex_i, ex_if.bnn_ready_i} = v;
  endtask

  task automatic bump();
    exp_stall = exp_stall == SMAX ? SMAX : exp_stall + 1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic div_run(input int n);
    for (int k = 0; k < n; k++) begin
      drive(7'b0100000);
      #4;
      chk("div_ready_low", 32'(ex_if.ex_ready_o), 0);
      chk("div_wb", 32'(ex_if.wb_sel_o), 1);
      bump();
      next_cycle();
    end
    drive(7'b0100100);
    #4;
    chk("div_ready_high", 32'(ex_if.ex_ready_o), 1);
    chk("div_wb_done", 32'(ex_if.wb_sel_o), 1);
    chk("div_busy_done", 32'(ex_if.ex_busy_o), 1);
    next_cycle();
    drive(7'b0000000);
    #4;
    chk("div_stall", 32'(ex_if.stall_cnt_o), 32'(exp_stall));
    chk("div_back_idle", 32'(ex_if.ex_busy_o), 0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0]  = '{7'b0000000, 1'b1, 2'd0, 1'b0, 1'b0};
    tv[1]  = '{7'b0000000, 1'b1, 2'd0, 1'b0, 1'b0};
    tv[2]  = '{7'b0000000, 1'b1, 2'd0, 1'b0, 1'b0};
    tv[3]  = '{7'b0000000, 1'b1, 2'd0, 1'b0, 1'b0};
    tv[4]  = '{7'b0000000, 1'b1, 2'd0, 1'b0, 1'b0};
    tv[5]  = '{7'b0010010, 1'b1, 2'd3, 1'b0, 1'b0};
    tv[6]  = '{7'b0000000, 1'b1, 2'd0, 1'b0, 1'b0};
    tv[7]  = '{7'b1011000, 1'b0, 2'd1, 1'b0, 1'b0};
    tv[8]  = '{7'b1011000, 1'b0, 2'd1, 1'b1, 1'b1};
    tv[9]  = '{7'b1011100, 1'b1, 2'd1, 1'b1, 1'b0};
    tv[10] = '{7'b0000000, 1'b1, 2'd0, 1'b0, 1'b0};
    tv[11] = '{7'b0001000, 1'b0, 2'd2, 1'b0, 1'b0};
    tv[12] = '{7'b0001000, 1'b0, 2'd2, 1'b1, 1'b0};
    tv[13] = '{7'b0001000, 1'b0, 2'd2, 1'b1, 1'b0};
    tv[14] = '{7'b0000000, 1'b0, 2'd2, 1'b1, 1'b0};
    tv[15] = '{7'b0000000, 1'b1, 2'd0, 1'b0, 1'b0};
    tv[16] = '{7'b0000000, 1'b1, 2'd0, 1'b0, 1'b0};

    drive(7'b0000000);
    repeat (2) @(posedge clk);
    #4;
    chk("rst_ready", 32'(ex_if.ex_ready_o), 1);
    chk("rst_wb", 32'(ex_if.wb_sel_o), 0);
    chk("rst_busy", 32'(ex_if.ex_busy_o), 0);
    chk("rst_conflict", 32'(ex_if.en_conflict_o), 0);
    chk("rst_stall", 32'(ex_if.stall_cnt_o), 0);
    chk("rst_wdog", 32'(ex_if.wdog_timeout_o), 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 17; i++) begin
      drive(tv[i].in);
      #4;
      chk($sformatf("v%0d_ready", i), 32'(ex_if.ex_ready_o), 32'(tv[i].rdy));
      chk($sformatf("v%0d_wb", i), 32'(ex_if.wb_sel_o), 32'(tv[i].wb));
      chk($sformatf("v%0d_busy", i), 32'(ex_if.ex_busy_o), 32'(tv[i].busy));
      chk($sformatf("v%0d_conflict", i), 32'(ex_if.en_conflict_o), 32'(tv[i].conf));
      chk($sformatf("v%0d_stall", i), 32'(ex_if.stall_cnt_o), 32'(exp_stall));
      chk($sformatf("v%0d_wdog", i), 32'(ex_if.wdog_timeout_o), 0);
      if (!tv[i].rdy) bump();
      next_cycle();
    end

`ifdef ZERORISCY_EX_WDOG_EN
    for (int i = 0; i < 9; i++) begin
      drive(7'b0001000);
      #4;
      chk($sformatf("wd%0d_ready", i), 32'(ex_if.ex_ready_o), 32'(i == 8));
      chk($sformatf("wd%0d_timeout", i), 32'(ex_if.wdog_timeout_o), 32'(i == 8));
      chk($sformatf("wd%0d_busy", i), 32'(ex_if.ex_busy_o), 32'(i > 0));
      if (i != 8) bump();
      next_cycle();
    end
    drive(7'b0000000);
    #4;
    chk("wd_idle_busy", 32'(ex_if.ex_busy_o), 0);
    chk("wd_idle_ready", 32'(ex_if.ex_ready_o), 1);
    chk("wd_idle_timeout", 32'(ex_if.wdog_timeout_o), 0);
    chk("wd_stall", 32'(ex_if.stall_cnt_o), 32'(exp_stall));
    next_cycle();
    for (int i = 0; i < 9; i++) begin
      drive(i == 8 ? 7'b0001001 : 7'b0001000);
      #4;
      chk($sformatf("wdr%0d_ready", i), 32'(ex_if.ex_ready_o), 32'(i == 8));
      chk($sformatf("wdr%0d_timeout", i), 32'(ex_if.wdog_timeout_o), 0);
      if (i != 8) bump();
      next_cycle();
    end
    drive(7'b0000000);
    next_cycle();
`else
    div_run(34);
    div_run(30);
    chk("stall_saturated", 32'(ex_if.stall_cnt_o), 32'(SMAX));
    div_run(3);
    chk("stall_no_wrap", 32'(ex_if.stall_cnt_o), 32'(SMAX));
`endif

    drive(7'b0100000);
    #4;
    bump();
    next_cycle();
    #4;
    chk("mid_busy_before_rst", 32'(ex_if.ex_busy_o), 1);
    rst_n = 1'b0;
    #1;
    exp_stall = 0;
    chk("mid_rst_busy", 32'(ex_if.ex_busy_o), 0);
    chk("mid_rst_stall", 32'(ex_if.stall_cnt_o), 0);
    chk("mid_rst_ready_en", 32'(ex_if.ex_ready_o), 0);
    drive(7'b0000000);
    #1;
    chk("mid_rst_ready", 32'(ex_if.ex_ready_o), 1);
    chk("mid_rst_wb", 32'(ex_if.wb_sel_o), 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    #4;
    chk("post_rst_busy", 32'(ex_if.ex_busy_o), 0);
    chk("post_rst_stall", 32'(ex_if.stall_cnt_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
